prog_seq_counter: RTL and testbench
===================================

PROG_SEQ_COUNTER -- requirements
Module: prog_seq_counter

Interface
REQ-001 Parameter WIDTH, default 3, SHALL set the bit width of each sequence value and of countreg.
REQ-002 Parameter DEPTH, default 8, SHALL set the number of sequence table entries; legal range is 2..256.
REQ-003 Parameter IW, default clog2(DEPTH), SHALL set the index width; IW is derived and SHALL NOT be overridden.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 en  input  1  SHALL allow one step per cycle when high and hold state when low.
REQ-007 dir  input  1  SHALL select the step direction: 0 is forward (idx+1), 1 is reverse (idx-1).
REQ-008 load  input  1  SHALL force the index to load_idx on the next edge.
REQ-009 load_idx  input  IW  SHALL be the target index for load.
REQ-010 wr_en  input  1  SHALL write wr_data into table[wr_addr].
REQ-011 wr_addr  input  IW  SHALL be the table write address; writes with wr_addr >= DEPTH SHALL be ignored.
REQ-012 wr_data  input  WIDTH  SHALL be the table write data.
REQ-013 len_we  input  1  SHALL load the active-length register from len_in.
REQ-014 len_in  input  IW+1  SHALL be the new active length; 0 SHALL clamp to 1, and values > DEPTH SHALL clamp to DEPTH.
REQ-015 countreg  output  WIDTH  SHALL equal table[idx] combinationally from registered idx and table.
REQ-016 idx  output  IW  SHALL be the current sequence index.
REQ-017 wrap  output  1  SHALL be a registered one-cycle pulse on every wrap-around step.

Function
REQ-018 Forward step SHALL go idx -> idx+1, and from idx >= len-1 SHALL go to 0 with wrap=1.
REQ-019 Reverse step SHALL go idx -> idx-1, and from idx == 0 or idx >= len SHALL go to len-1 with wrap=1.
REQ-020 Priority SHALL be load > en; a load SHALL never assert wrap.
REQ-021 A load_idx >= len SHALL be treated as index 0.
REQ-022 A table write SHALL take effect after the clock edge; a write to the current idx SHALL change countreg in the following cycle.
REQ-023 Simultaneous wr_en and step SHALL both complete in the same cycle; countreg SHALL then show the new idx entry including the write if addresses match.
REQ-024 A len change SHALL apply to the next step decision; if idx >= new len, the next forward step SHALL go to 0 and assert wrap.
REQ-025 Simultaneous len_we and step SHALL evaluate the step against the old len.
REQ-026 With en=0 and load=0, idx SHALL hold and wrap SHALL be 0.
REQ-027 If len=1, every enabled step SHALL keep idx=0 and SHALL assert wrap.

Reset
REQ-028 rst SHALL asynchronously clear idx to 0 and wrap to 0.
REQ-029 rst SHALL set len to DEPTH and table[i] to i mod 2^WIDTH, so countreg is 0 out of reset.
REQ-030 Deasserting rst mid-sequence SHALL restart stepping from idx=0 on the first enabled edge.

Structure
REQ-031 Package prog_seq_pkg SHALL hold the default WIDTH and DEPTH, the clog2 function, and the direction encodings DIR_FWD=0 and DIR_REV=1.
REQ-032 The table SHALL be a sub-module seq_table: a DEPTH x WIDTH register file with reset, one write port and one asynchronous read port.
REQ-033 Next-index logic SHALL be combinational, with a single registered state update.

Verification
REQ-034 Reset, then write table[0..4]=0,6,1,4,3, len=5, en=1, dir=0 -> countreg SHALL be 0,6,1,4,3,0,6, with wrap on the step from 3 to 0.
REQ-035 Same table, dir=1 from idx=0 -> countreg SHALL be 0,3,4,1,6,0, with wrap on the first step.
REQ-036 load=1, load_idx=3 with en=1 at idx=1 -> idx SHALL be 3, countreg 4, wrap 0; load_idx=6 with len=5 -> idx SHALL be 0.
REQ-037 At idx=4 with len=5, write len=3 -> next forward step SHALL give idx=0 with wrap=1; a len_we coincident with a step SHALL use the old len.
REQ-038 Assert rst mid-sequence at idx=3 -> idx, countreg and wrap SHALL be 0 immediately (without a clock), len SHALL be 8, and the table SHALL be the identity.
REQ-039 en=0 for 5 cycles -> idx SHALL be unchanged; wr_en to table[idx]=7 -> countreg SHALL be 7 next cycle.

Source files
------------

// File: rtl/prog_seq_pkg.sv
// Shared defaults, index-width helper and step-direction encodings for the
// programmable sequence counter.
package prog_seq_pkg;

  localparam int unsigned DEF_WIDTH = 3;
  localparam int unsigned DEF_DEPTH = 8;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // Smallest r with 2**r >= n; at least 1 for n >= 2.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/prog_seq_counter_if.sv
// Control/status bundle of prog_seq_counter.
//   master: drives en, dir, load, load_idx, wr_*, len_*; observes countreg, idx, wrap
//   slave : the counter side of the same signals
interface prog_seq_counter_if
  import prog_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
);
  localparam int unsigned IW = clog2(DEPTH);

  logic             en;
  logic             dir;
  logic             load;
  logic [IW-1:0]    load_idx;
  logic             wr_en;
  logic [IW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             len_we;
  logic [IW:0]      len_in;
  logic [WIDTH-1:0] countreg;
  logic [IW-1:0]    idx;
  logic             wrap;

  modport master (
    output en, dir, load, load_idx, wr_en, wr_addr, wr_data, len_we, len_in,
    input  countreg, idx, wrap
  );

  modport slave (
    input  en, dir, load, load_idx, wr_en, wr_addr, wr_data, len_we, len_in,
    output countreg, idx, wrap
  );

endinterface

// File: rtl/seq_table.sv
// DEPTH x WIDTH sequence register file: one write port, one async read port.
// Reset loads the identity pattern (entry i = i mod 2**WIDTH).
//   clk, rst          : clock, async active-high reset
//   wr_en/addr/data   : write port; addresses >= DEPTH are dropped
//   rd_addr, rd_data  : combinational read
module seq_table #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage with identity reset pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= WIDTH'(i);
    end else if (wr_en && (32'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/prog_seq_counter.sv
// Programmable sequence counter: steps an index through a writable table of
// WIDTH-bit values, forward or reverse, over an adjustable active length.
//   clk, rst : clock, async active-high reset
//   bus      : control inputs (en, dir, load, load_idx, wr_*, len_*) and
//              outputs countreg (= table[idx]), idx, wrap (one-cycle pulse)
module prog_seq_counter
  import prog_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  prog_seq_counter_if.slave   bus
);

  localparam int unsigned IW = clog2(DEPTH);
  localparam int unsigned LW = IW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [IW-1:0] idx_q, idx_d;
  logic          wrap_q, wrap_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_ext, len_m1;

  assign idx_ext = LW'(idx_q);
  assign len_m1  = len_q - LW'(1);   // len_q is never 0

  // New active length, clamped to 1..DEPTH.
  always_comb begin
    len_d = len_q;
    if (bus.len_we) begin
      if (bus.len_in == '0)          len_d = LW'(1);
      else if (bus.len_in > DEPTH_L) len_d = DEPTH_L;
      else                           len_d = bus.len_in;
    end
  end

  // Next index and wrap flag; decisions use the current (old) length.
  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      idx_d = (LW'(bus.load_idx) >= len_q) ? '0 : bus.load_idx;
    end else if (bus.en) begin
      if (bus.dir == DIR_FWD) begin
        if (idx_ext >= len_m1) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end else begin
        if ((idx_q == '0) || (idx_ext >= len_q)) begin
          idx_d  = IW'(len_m1);
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
    end
  end

  // Single registered state update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      wrap_q <= 1'b0;
      len_q  <= DEPTH_L;
    end else begin
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
      len_q  <= len_d;
    end
  end

  seq_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (idx_q),
    .rd_data (bus.countreg)
  );

  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_prog_seq_counter.sv
// Directed bench for prog_seq_counter (WIDTH=3, DEPTH=8).
module tb_prog_seq_counter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  prog_seq_counter_if #(.WIDTH(3), .DEPTH(8)) bus ();

  prog_seq_counter #(.WIDTH(3), .DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic       en;
    logic       dir;
    logic       load;
    logic [2:0] load_idx;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [2:0] wr_data;
    logic       len_we;
    logic [3:0] len_in;
    logic [2:0] e_idx;
    logic [2:0] e_cnt;
    logic       e_wrap;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic en, input logic dir, input logic load,
                     input int lidx, input logic we, input int wa, input int wd,
                     input logic lwe, input int lin,
                     input int eidx, input int ecnt, input logic ewrap);
    vec_t v;
    v.en = en; v.dir = dir; v.load = load; v.load_idx = 3'(lidx);
    v.wr_en = we; v.wr_addr = 3'(wa); v.wr_data = 3'(wd);
    v.len_we = lwe; v.len_in = 4'(lin);
    v.e_idx = 3'(eidx); v.e_cnt = 3'(ecnt); v.e_wrap = ewrap;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int eidx, input int ecnt, input int ewrap);
    chk({tag, ".idx"},      int'(bus.idx),      eidx);
    chk({tag, ".countreg"}, int'(bus.countreg), ecnt);
    chk({tag, ".wrap"},     int'(bus.wrap),     ewrap);
  endtask

  task automatic idle_inputs();
    bus.en = 0; bus.dir = 0; bus.load = 0; bus.load_idx = '0;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.len_we = 0; bus.len_in = '0;
  endtask

  initial begin
    // en dir ld lidx we wa wd lwe lin | idx cnt wrap
    add(0,0,0,0, 1,0,0, 0,0,  0,0,0);   // program table 0..4
    add(0,0,0,0, 1,1,6, 0,0,  0,0,0);
    add(0,0,0,0, 1,2,1, 0,0,  0,0,0);
    add(0,0,0,0, 1,3,4, 0,0,  0,0,0);
    add(0,0,0,0, 1,4,3, 0,0,  0,0,0);
    add(0,0,0,0, 0,0,0, 1,5,  0,0,0);   // len=5
    add(1,0,0,0, 0,0,0, 0,0,  1,6,0);   // forward run
    add(1,0,0,0, 0,0,0, 0,0,  2,1,0);
    add(1,0,0,0, 0,0,0, 0,0,  3,4,0);
    add(1,0,0,0, 0,0,0, 0,0,  4,3,0);
    add(1,0,0,0, 0,0,0, 0,0,  0,0,1);
    add(1,0,0,0, 0,0,0, 0,0,  1,6,0);
    add(0,0,1,0, 0,0,0, 0,0,  0,0,0);   // back to 0
    add(1,1,0,0, 0,0,0, 0,0,  4,3,1);   // reverse run
    add(1,1,0,0, 0,0,0, 0,0,  3,4,0);
    add(1,1,0,0, 0,0,0, 0,0,  2,1,0);
    add(1,1,0,0, 0,0,0, 0,0,  1,6,0);
    add(1,1,0,0, 0,0,0, 0,0,  0,0,0);
    add(1,0,0,0, 0,0,0, 0,0,  1,6,0);
    add(1,0,1,3, 0,0,0, 0,0,  3,4,0);   // load beats en
    add(1,0,1,6, 0,0,0, 0,0,  0,0,0);   // load_idx >= len -> 0
    add(0,0,1,4, 0,0,0, 0,0,  4,3,0);   // load_idx == len-1 accepted
    add(0,0,1,5, 0,0,0, 0,0,  0,0,0);   // load_idx == len -> 0
    add(0,0,1,4, 0,0,0, 0,0,  4,3,0);
    add(0,0,0,0, 0,0,0, 1,3,  4,3,0);   // shrink len below idx
    add(1,0,0,0, 0,0,0, 0,0,  0,0,1);
    add(1,0,0,0, 0,0,0, 0,0,  1,6,0);
    add(1,0,0,0, 0,0,0, 0,0,  2,1,0);
    add(1,0,0,0, 0,0,0, 1,5,  0,0,1);   // step uses old len=3
    add(0,0,1,3, 0,0,0, 0,0,  3,4,0);   // new len=5 in force
    add(1,0,0,0, 0,0,0, 0,0,  4,3,0);
    add(0,0,0,0, 0,0,0, 1,2,  4,3,0);   // len=2, idx beyond
    add(1,1,0,0, 0,0,0, 0,0,  1,6,1);   // reverse from idx>=len
    add(0,0,0,0, 0,0,0, 1,0,  1,6,0);   // len 0 clamps to 1
    add(1,0,0,0, 0,0,0, 0,0,  0,0,1);
    add(1,0,0,0, 0,0,0, 0,0,  0,0,1);
    add(1,1,0,0, 0,0,0, 0,0,  0,0,1);
    add(0,0,0,0, 0,0,0, 1,15, 0,0,0);   // len 15 clamps to 8
    add(0,0,1,7, 0,0,0, 0,0,  7,7,0);
    add(1,0,1,7, 0,0,0, 0,0,  7,7,0);   // load at wrap point: no wrap
    add(1,0,0,0, 0,0,0, 0,0,  0,0,1);
    add(0,0,1,3, 0,0,0, 0,0,  3,4,0);
    for (int k = 0; k < 5; k++)
      add(0,0,0,0, 0,0,0, 0,0, 3,4,0);  // hold
    add(0,0,0,0, 1,3,7, 0,0,  3,7,0);   // write current entry
    add(1,0,0,0, 1,4,5, 0,0,  4,5,0);   // write + step to same entry
    add(1,1,0,0, 1,5,2, 0,0,  3,7,0);   // write elsewhere + step

    idle_inputs();
    rst = 1'b1;
    #1;
    chk_all("reset", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      bus.en = vq[i].en; bus.dir = vq[i].dir; bus.load = vq[i].load;
      bus.load_idx = vq[i].load_idx; bus.wr_en = vq[i].wr_en;
      bus.wr_addr = vq[i].wr_addr; bus.wr_data = vq[i].wr_data;
      bus.len_we = vq[i].len_we; bus.len_in = vq[i].len_in;
      @(posedge clk);
      #1;
      chk_all($sformatf("v%0d", i), int'(vq[i].e_idx), int'(vq[i].e_cnt), int'(vq[i].e_wrap));
    end

    // Write to current entry is invisible until after the edge.
    @(negedge clk);
    idle_inputs();
    bus.wr_en = 1; bus.wr_addr = 3'd3; bus.wr_data = 3'd1;
    #1;
    chk("wr_pre.countreg", int'(bus.countreg), 7);
    @(posedge clk);
    #1;
    chk("wr_post.countreg", int'(bus.countreg), 1);

    // Asynchronous reset mid-sequence at idx=3.
    @(negedge clk);
    idle_inputs();
    bus.en = 1;
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("rst_held", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // After reset: len=8 and identity table.
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      chk_all($sformatf("post_rst%0d", k), k % 8, k % 8, (k == 8) ? 1 : 0);
    end
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #1;
    chk_all("idle_after", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
